// File: rtl/scoreboard.sv
// In-order issue / in-order commit scoreboard with writeback collection and operand lookup.
// Types shared with the rest of the core live in ariane_pkg; NR_ENTRIES must equal 2**TRANS_ID_BITS.
package ariane_pkg;
  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned NR_WB_PORTS   = 3;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [6:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    logic                     use_imm;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

module scoreboard
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = NR_SB_ENTRIES,
  parameter int unsigned NR_WB      = NR_WB_PORTS
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  scoreboard_entry_t                  issue_entry_i,
  input  logic                               issue_valid_i,
  output logic                               issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]           trans_id_o,
  input  logic [4:0]                         rs1_i,
  input  logic [4:0]                         rs2_i,
  output logic                               rs1_busy_o,
  output logic                               rs2_busy_o,
  output logic                               rs1_fwd_valid_o,
  output logic                               rs2_fwd_valid_o,
  output logic [63:0]                        rs1_fwd_o,
  output logic [63:0]                        rs2_fwd_o,
  input  logic [NR_WB-1:0]                   wb_valid_i,
  input  logic [NR_WB*TRANS_ID_BITS-1:0]     wb_trans_id_i,
  input  logic [NR_WB*64-1:0]                wb_data_i,
  input  logic [NR_WB*$bits(exception_t)-1:0] wb_ex_i,
  output scoreboard_entry_t                  commit_o,
  output logic                               commit_valid_o,
  input  logic                               commit_ack_i
);
  localparam int unsigned EX_W  = $bits(exception_t);
  localparam int unsigned CNT_W = $clog2(NR_ENTRIES + 1);

  typedef struct packed {
    logic        busy;
    logic        fwd_valid;
    logic [63:0] fwd;
  } query_t;

  scoreboard_entry_t          mem_q [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]      alloc_q;
  logic [NR_ENTRIES-1:0]      valid_q;
  logic [TRANS_ID_BITS-1:0]   issue_ptr_q;
  logic [TRANS_ID_BITS-1:0]   commit_ptr_q;
  logic [CNT_W-1:0]           count_q;

  logic                       issue_fire;
  logic                       commit_fire;
  scoreboard_entry_t          issue_rec;
  logic [TRANS_ID_BITS-1:0]   wb_id   [NR_WB];
  logic [63:0]                wb_data [NR_WB];
  exception_t                 wb_ex   [NR_WB];
  logic                       wb_conflict;
  query_t                     q1;
  query_t                     q2;

  assign issue_ready_o  = (count_q != CNT_W'(NR_ENTRIES));
  assign trans_id_o     = issue_ptr_q;
  assign commit_valid_o = (count_q != '0) && valid_q[commit_ptr_q];
  assign issue_fire     = issue_valid_i && issue_ready_o;
  assign commit_fire    = commit_ack_i && commit_valid_o;

  // Decode-side exceptions are complete on arrival, so they need no writeback.
  always_comb begin
    issue_rec          = issue_entry_i;
    issue_rec.trans_id = issue_ptr_q;
    issue_rec.valid    = issue_entry_i.ex.valid;
  end

  always_comb begin
    commit_o       = mem_q[commit_ptr_q];
    commit_o.valid = valid_q[commit_ptr_q];
  end

  always_comb begin
    for (int p = 0; p < NR_WB; p++) begin
      wb_id[p]   = wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS];
      wb_data[p] = wb_data_i[p*64 +: 64];
      wb_ex[p]   = wb_ex_i[p*EX_W +: EX_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      alloc_q      <= '0;
      valid_q      <= '0;
    end else begin
      if (issue_fire) begin
        alloc_q[issue_ptr_q] <= 1'b1;
        valid_q[issue_ptr_q] <= issue_entry_i.ex.valid;
        issue_ptr_q          <= issue_ptr_q + 1'b1;
      end
      for (int p = 0; p < NR_WB; p++) begin
        if (wb_valid_i[p] && alloc_q[wb_id[p]]) valid_q[wb_id[p]] <= 1'b1;
      end
      if (commit_fire) begin
        alloc_q[commit_ptr_q] <= 1'b0;
        valid_q[commit_ptr_q] <= 1'b0;
        commit_ptr_q          <= commit_ptr_q + 1'b1;
      end
      case ({issue_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage; later ports overwrite earlier ones on a shared slot.
  always_ff @(posedge clk_i) begin
    if (issue_fire) mem_q[issue_ptr_q] <= issue_rec;
    for (int p = 0; p < NR_WB; p++) begin
      if (wb_valid_i[p] && alloc_q[wb_id[p]]) begin
        mem_q[wb_id[p]].result <= wb_data[p];
        if (wb_ex[p].valid) mem_q[wb_id[p]].ex <= wb_ex[p];
      end
    end
  end

  // Oldest-to-youngest walk; the last hit is the youngest writer.
  function automatic query_t lookup(input logic [4:0] rs);
    query_t                   r;
    logic [TRANS_ID_BITS-1:0] idx;
    r = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      idx = commit_ptr_q + TRANS_ID_BITS'(i);
      if (rs != 5'd0 && CNT_W'(i) < count_q && alloc_q[idx] && mem_q[idx].rd == rs) begin
        r.busy      = 1'b1;
        r.fwd_valid = valid_q[idx] && !mem_q[idx].ex.valid;
        r.fwd       = mem_q[idx].result;
      end
    end
    return r;
  endfunction

  always_comb begin
    q1 = lookup(rs1_i);
    q2 = lookup(rs2_i);
  end

  assign rs1_busy_o      = q1.busy;
  assign rs1_fwd_valid_o = q1.fwd_valid;
  assign rs1_fwd_o       = q1.fwd;
  assign rs2_busy_o      = q2.busy;
  assign rs2_fwd_valid_o = q2.fwd_valid;
  assign rs2_fwd_o       = q2.fwd;

  always_comb begin
    wb_conflict = 1'b0;
    for (int p = 0; p < NR_WB; p++) begin
      for (int q = p + 1; q < NR_WB; q++) begin
        if (wb_valid_i[p] && wb_valid_i[q] && wb_id[p] == wb_id[q]) wb_conflict = 1'b1;
      end
    end
  end

  wb_same_slot: assert property (@(posedge clk_i) disable iff (rst_i) !wb_conflict);

endmodule

// File: tb/tb_scoreboard.sv
// Bench for scoreboard: directed scenarios plus a randomized run against a queue-based model.
module tb_scoreboard;
  import ariane_pkg::*;

  localparam int N   = NR_SB_ENTRIES;
  localparam int WB  = NR_WB_PORTS;
  localparam int TW  = TRANS_ID_BITS;
  localparam int EXW = $bits(exception_t);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  scoreboard_entry_t     issue_entry;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [TW-1:0]         trans_id;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  rs1_fwd_valid;
  logic                  rs2_fwd_valid;
  logic [63:0]           rs1_fwd;
  logic [63:0]           rs2_fwd;
  logic [WB-1:0]         wb_valid;
  logic [WB*TW-1:0]      wb_trans_id;
  logic [WB*64-1:0]      wb_data;
  logic [WB*EXW-1:0]     wb_ex;
  scoreboard_entry_t     commit;
  logic                  commit_valid;
  logic                  commit_ack;

  scoreboard dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .issue_entry_i   (issue_entry),
    .issue_valid_i   (issue_valid),
    .issue_ready_o   (issue_ready),
    .trans_id_o      (trans_id),
    .rs1_i           (rs1),
    .rs2_i           (rs2),
    .rs1_busy_o      (rs1_busy),
    .rs2_busy_o      (rs2_busy),
    .rs1_fwd_valid_o (rs1_fwd_valid),
    .rs2_fwd_valid_o (rs2_fwd_valid),
    .rs1_fwd_o       (rs1_fwd),
    .rs2_fwd_o       (rs2_fwd),
    .wb_valid_i      (wb_valid),
    .wb_trans_id_i   (wb_trans_id),
    .wb_data_i       (wb_data),
    .wb_ex_i         (wb_ex),
    .commit_o        (commit),
    .commit_valid_o  (commit_valid),
    .commit_ack_i    (commit_ack)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: in-flight instructions in program order, oldest at index 0.
  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic [63:0] result;
    bit          done;
    bit          exv;
    logic [63:0] cause;
  } m_ent_t;

  m_ent_t m_q[$];
  int     m_next_id = 0;

  task automatic idle();
    issue_valid = 1'b0;
    issue_entry = '0;
    flush       = 1'b0;
    commit_ack  = 1'b0;
    wb_valid    = '0;
    wb_trans_id = '0;
    wb_data     = '0;
    wb_ex       = '0;
    rs1         = 5'd0;
    rs2         = 5'd0;
  endtask

  function automatic scoreboard_entry_t mk_entry(input logic [4:0] rd, input bit exv, input logic [63:0] cause);
    scoreboard_entry_t e;
    e          = '0;
    e.pc       = {$urandom, $urandom};
    e.trans_id = TW'($urandom);
    e.fu       = 4'($urandom);
    e.op       = 7'($urandom);
    e.rs1      = 5'($urandom);
    e.rs2      = 5'($urandom);
    e.rd       = rd;
    e.result   = {$urandom, $urandom};
    e.valid    = 1'($urandom);
    e.use_imm  = 1'($urandom);
    e.ex.valid = exv;
    e.ex.cause = cause;
    e.ex.tval  = {$urandom, $urandom};
    return e;
  endfunction

  task automatic set_wb(input int p, input int id, input logic [63:0] data, input bit exv, input logic [63:0] cause);
    exception_t x;
    x       = '0;
    x.valid = exv;
    x.cause = cause;
    wb_valid[p]                = 1'b1;
    wb_trans_id[p*TW +: TW]    = TW'(id);
    wb_data[p*64 +: 64]        = data;
    wb_ex[p*EXW +: EXW]        = x;
  endtask

  // Advances the model from the current inputs, then lets the DUT take the same edge.
  task automatic clock_cycle();
    bit         iss;
    bit         com;
    int         id;
    exception_t x;
    m_ent_t     e;
    if (rst || flush) begin
      m_q.delete();
      m_next_id = 0;
    end else begin
      iss = issue_valid && (m_q.size() < N);
      com = commit_ack && (m_q.size() > 0) && m_q[0].done;
      for (int p = 0; p < WB; p++) begin
        if (wb_valid[p]) begin
          id = int'(wb_trans_id[p*TW +: TW]);
          x  = wb_ex[p*EXW +: EXW];
          foreach (m_q[j]) begin
            if (m_q[j].id == id) begin
              m_q[j].result = wb_data[p*64 +: 64];
              m_q[j].done   = 1'b1;
              if (x.valid) begin
                m_q[j].exv   = 1'b1;
                m_q[j].cause = x.cause;
              end
            end
          end
        end
      end
      if (com) void'(m_q.pop_front());
      if (iss) begin
        e.id     = m_next_id;
        e.rd     = issue_entry.rd;
        e.result = issue_entry.result;
        e.done   = issue_entry.ex.valid;
        e.exv    = issue_entry.ex.valid;
        e.cause  = issue_entry.ex.cause;
        m_q.push_back(e);
        m_next_id = (m_next_id + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void m_query(input logic [4:0] rs, output bit busy, output bit fv, output logic [63:0] fwd);
    busy = 1'b0;
    fv   = 1'b0;
    fwd  = '0;
    if (rs == 5'd0) return;
    for (int j = m_q.size() - 1; j >= 0; j--) begin
      if (m_q[j].rd == rs) begin
        busy = 1'b1;
        fv   = m_q[j].done && !m_q[j].exv;
        fwd  = m_q[j].result;
        break;
      end
    end
  endfunction

  task automatic do_reset();
    idle();
    rst = 1'b1;
    clock_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rs1 = 5'd3;
    rs2 = 5'd7;
    #1;
    vec_cnt++; if (issue_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_issue_ready got %0b want 1", issue_ready); end
    vec_cnt++; if (trans_id !== '0) begin err_cnt++; $display("FAIL reset_trans_id got %0d want 0", trans_id); end
    vec_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_commit_valid got %0b want 0", commit_valid); end
    vec_cnt++; if ({rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid} !== 4'b0) begin
      err_cnt++; $display("FAIL reset_query got %b want 0000", {rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid});
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < N; k++) begin
      idle();
      issue_valid = 1'b1;
      issue_entry = mk_entry(5'(k + 1), 1'b0, 64'd0);
      #1;
      vec_cnt++; if (trans_id !== TW'(k)) begin err_cnt++; $display("FAIL fill_trans_id got %0d want %0d", trans_id, k); end
      vec_cnt++; if (issue_ready !== 1'b1) begin err_cnt++; $display("FAIL fill_ready got %0b want 1", issue_ready); end
      clock_cycle();
    end
    idle();
    issue_valid = 1'b1;
    issue_entry = mk_entry(5'd9, 1'b0, 64'd0);
    #1;
    vec_cnt++; if (issue_ready !== 1'b0) begin err_cnt++; $display("FAIL full_ready got %0b want 0", issue_ready); end
    vec_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL full_commit_valid got %0b want 0", commit_valid); end
    clock_cycle();
    idle();
    rs1 = 5'd9;
    rs2 = 5'd4;
    #1;
    vec_cnt++; if (rs1_busy !== 1'b0) begin err_cnt++; $display("FAIL fifth_issue_busy got %0b want 0", rs1_busy); end
    vec_cnt++; if (rs2_busy !== 1'b1 || rs2_fwd_valid !== 1'b0) begin
      err_cnt++; $display("FAIL full_rd4_query got busy=%0b fv=%0b want busy=1 fv=0", rs2_busy, rs2_fwd_valid);
    end
    vec_cnt++; if (issue_ready !== 1'b0) begin err_cnt++; $display("FAIL still_full_ready got %0b want 0", issue_ready); end
  endtask

  task automatic test_full_commit_wrap();
    idle();
    set_wb(0, 0, 64'hDEAD, 1'b0, 64'd0);
    #1;
    clock_cycle();
    idle();
    commit_ack  = 1'b1;
    issue_valid = 1'b1;
    issue_entry = mk_entry(5'd7, 1'b0, 64'd0);
    #1;
    vec_cnt++; if (commit_valid !== 1'b1) begin err_cnt++; $display("FAIL wrap_commit_valid got %0b want 1", commit_valid); end
    vec_cnt++; if (commit.result !== 64'hDEAD) begin err_cnt++; $display("FAIL wrap_commit_result got %h want dead", commit.result); end
    vec_cnt++; if (commit.trans_id !== TW'(0)) begin err_cnt++; $display("FAIL wrap_commit_id got %0d want 0", commit.trans_id); end
    vec_cnt++; if (issue_ready !== 1'b0) begin err_cnt++; $display("FAIL ack_cycle_ready got %0b want 0", issue_ready); end
    clock_cycle();
    idle();
    issue_valid = 1'b1;
    issue_entry = mk_entry(5'd7, 1'b0, 64'd0);
    rs1 = 5'd7;
    #1;
    vec_cnt++; if (issue_ready !== 1'b1) begin err_cnt++; $display("FAIL post_ack_ready got %0b want 1", issue_ready); end
    vec_cnt++; if (trans_id !== TW'(0)) begin err_cnt++; $display("FAIL wrap_trans_id got %0d want 0", trans_id); end
    vec_cnt++; if (rs1_busy !== 1'b0) begin err_cnt++; $display("FAIL ack_cycle_no_issue got busy=%0b want 0", rs1_busy); end
    vec_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL head1_commit_valid got %0b want 0", commit_valid); end
    clock_cycle();
    idle();
    rs1 = 5'd7;
    #1;
    vec_cnt++; if (trans_id !== TW'(1)) begin err_cnt++; $display("FAIL after_wrap_trans_id got %0d want 1", trans_id); end
    vec_cnt++; if (issue_ready !== 1'b0) begin err_cnt++; $display("FAIL refull_ready got %0b want 0", issue_ready); end
    vec_cnt++; if (rs1_busy !== 1'b1) begin err_cnt++; $display("FAIL wrapped_entry_busy got %0b want 1", rs1_busy); end
  endtask

  task automatic test_ooo_wb();
    logic [63:0] d [3];
    int          id;
    d[0] = 64'h50;
    d[1] = 64'h100;
    d[2] = 64'h200;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      issue_valid = 1'b1;
      issue_entry = mk_entry(5'(k + 1), 1'b0, 64'd0);
      #1;
      clock_cycle();
    end
    for (int s = 0; s < 3; s++) begin
      id = 2 - s;
      idle();
      commit_ack = 1'b1;
      set_wb(s, id, d[id], 1'b0, 64'd0);
      #1;
      vec_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL ooo_wait_%0d got commit_valid=%0b want 0", s, commit_valid); end
      clock_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      commit_ack = 1'b1;
      #1;
      vec_cnt++; if (commit_valid !== 1'b1 || commit.trans_id !== TW'(k) || commit.result !== d[k]) begin
        err_cnt++; $display("FAIL ooo_commit_%0d got v=%0b id=%0d res=%h want v=1 id=%0d res=%h", k, commit_valid, commit.trans_id, commit.result, k, d[k]);
      end
      clock_cycle();
    end
    idle();
    #1;
    vec_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL ooo_drained got %0b want 0", commit_valid); end
  endtask

  task automatic test_forwarding();
    logic [4:0] rds [3];
    rds[0] = 5'd5;
    rds[1] = 5'd5;
    rds[2] = 5'd0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      issue_valid = 1'b1;
      issue_entry = mk_entry(rds[k], 1'b0, 64'd0);
      #1;
      clock_cycle();
    end
    idle();
    set_wb(0, 0, 64'h11, 1'b0, 64'd0);
    set_wb(1, 2, 64'h33, 1'b0, 64'd0);
    #1;
    clock_cycle();
    idle();
    rs1 = 5'd5;
    set_wb(2, 1, 64'h22, 1'b0, 64'd0);
    #1;
    vec_cnt++; if (rs1_busy !== 1'b1 || rs1_fwd_valid !== 1'b0) begin
      err_cnt++; $display("FAIL fwd_youngest_pending got busy=%0b fv=%0b want busy=1 fv=0", rs1_busy, rs1_fwd_valid);
    end
    clock_cycle();
    idle();
    rs1 = 5'd5;
    rs2 = 5'd5;
    #1;
    vec_cnt++; if (rs1_busy !== 1'b1 || rs1_fwd_valid !== 1'b1 || rs1_fwd !== 64'h22) begin
      err_cnt++; $display("FAIL fwd_rs1 got busy=%0b fv=%0b fwd=%h want 1 1 22", rs1_busy, rs1_fwd_valid, rs1_fwd);
    end
    vec_cnt++; if (rs2_fwd_valid !== 1'b1 || rs2_fwd !== 64'h22) begin
      err_cnt++; $display("FAIL fwd_rs2 got fv=%0b fwd=%h want 1 22", rs2_fwd_valid, rs2_fwd);
    end
    rs1 = 5'd0;
    #1;
    vec_cnt++; if (rs1_busy !== 1'b0 || rs1_fwd_valid !== 1'b0) begin
      err_cnt++; $display("FAIL fwd_x0 got busy=%0b fv=%0b want 0 0", rs1_busy, rs1_fwd_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle();
      issue_valid = 1'b1;
      issue_entry = mk_entry(5'(10 + k), 1'b0, 64'd0);
      #1;
      clock_cycle();
    end
    idle();
    flush       = 1'b1;
    issue_valid = 1'b1;
    issue_entry = mk_entry(5'd13, 1'b0, 64'd0);
    set_wb(0, 1, 64'h77, 1'b0, 64'd0);
    #1;
    clock_cycle();
    idle();
    rs1 = 5'd11;
    rs2 = 5'd13;
    #1;
    vec_cnt++; if (commit_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_commit_valid got %0b want 0", commit_valid); end
    vec_cnt++; if (trans_id !== TW'(0)) begin err_cnt++; $display("FAIL flush_trans_id got %0d want 0", trans_id); end
    vec_cnt++; if (issue_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_ready got %0b want 1", issue_ready); end
    vec_cnt++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      err_cnt++; $display("FAIL flush_busy got rs1=%0b rs2=%0b want 0 0", rs1_busy, rs2_busy);
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      issue_valid = 1'b1;
      issue_entry = mk_entry(5'(1 + k), 1'b0, 64'd0);
      #1;
      clock_cycle();
    end
    idle();
    #1;
    vec_cnt++; if (issue_ready !== 1'b1 || trans_id !== TW'(3)) begin
      err_cnt++; $display("FAIL flush_count got ready=%0b id=%0d want 1 3", issue_ready, trans_id);
    end
  endtask

  task automatic test_decode_exception();
    do_reset();
    idle();
    issue_valid = 1'b1;
    issue_entry = mk_entry(5'd6, 1'b1, ILLEGAL_INSTR);
    #1;
    clock_cycle();
    idle();
    rs1 = 5'd6;
    #1;
    vec_cnt++; if (commit_valid !== 1'b1) begin err_cnt++; $display("FAIL dec_ex_commit_valid got %0b want 1", commit_valid); end
    vec_cnt++; if (commit.ex.valid !== 1'b1 || commit.ex.cause !== ILLEGAL_INSTR) begin
      err_cnt++; $display("FAIL dec_ex_cause got v=%0b cause=%0d want 1 2", commit.ex.valid, commit.ex.cause);
    end
    vec_cnt++; if (rs1_busy !== 1'b1 || rs1_fwd_valid !== 1'b0) begin
      err_cnt++; $display("FAIL dec_ex_query got busy=%0b fv=%0b want 1 0", rs1_busy, rs1_fwd_valid);
    end
    commit_ack = 1'b1;
    clock_cycle();
    idle();
    #1;
    vec_cnt++; if (commit_valid !== 1'b0 || issue_ready !== 1'b1) begin
      err_cnt++; $display("FAIL dec_ex_drain got v=%0b ready=%0b want 0 1", commit_valid, issue_ready);
    end
  endtask

  task automatic test_random();
    bit          used [N];
    int          id;
    bit          exp_cv;
    bit          b;
    bit          fv;
    logic [63:0] fwd;
    do_reset();
    repeat (600) begin
      idle();
      flush       = ($urandom_range(0, 63) == 0);
      issue_valid = 1'($urandom_range(0, 1));
      issue_entry = mk_entry(5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, 64'($urandom_range(0, 15)));
      commit_ack  = 1'($urandom_range(0, 1));
      rs1         = 5'($urandom_range(0, 7));
      rs2         = 5'($urandom_range(0, 7));
      foreach (used[i]) used[i] = 1'b0;
      for (int p = 0; p < WB; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          id = $urandom_range(0, N - 1);
          if (!used[id]) begin
            used[id] = 1'b1;
            set_wb(p, id, {$urandom, $urandom}, $urandom_range(0, 7) == 0, 64'($urandom_range(0, 15)));
          end
        end
      end
      #1;
      exp_cv = (m_q.size() > 0) && m_q[0].done;
      vec_cnt++; if (issue_ready !== (m_q.size() < N)) begin err_cnt++; $display("FAIL rnd_ready got %0b want %0b", issue_ready, m_q.size() < N); end
      vec_cnt++; if (trans_id !== TW'(m_next_id)) begin err_cnt++; $display("FAIL rnd_trans_id got %0d want %0d", trans_id, m_next_id); end
      vec_cnt++; if (commit_valid !== exp_cv) begin err_cnt++; $display("FAIL rnd_commit_valid got %0b want %0b", commit_valid, exp_cv); end
      if (exp_cv) begin
        vec_cnt++;
        if (commit.trans_id !== TW'(m_q[0].id) || commit.result !== m_q[0].result || commit.ex.valid !== m_q[0].exv ||
            (m_q[0].exv && commit.ex.cause !== m_q[0].cause)) begin
          err_cnt++;
          $display("FAIL rnd_commit got id=%0d res=%h exv=%0b cause=%0d want id=%0d res=%h exv=%0b cause=%0d",
                   commit.trans_id, commit.result, commit.ex.valid, commit.ex.cause,
                   m_q[0].id, m_q[0].result, m_q[0].exv, m_q[0].cause);
        end
      end
      m_query(rs1, b, fv, fwd);
      vec_cnt++; if (rs1_busy !== b || rs1_fwd_valid !== fv || (fv && rs1_fwd !== fwd)) begin
        err_cnt++; $display("FAIL rnd_rs1 rs=%0d got %0b %0b %h want %0b %0b %h", rs1, rs1_busy, rs1_fwd_valid, rs1_fwd, b, fv, fwd);
      end
      m_query(rs2, b, fv, fwd);
      vec_cnt++; if (rs2_busy !== b || rs2_fwd_valid !== fv || (fv && rs2_fwd !== fwd)) begin
        err_cnt++; $display("FAIL rnd_rs2 rs=%0d got %0b %0b %h want %0b %0b %h", rs2, rs2_busy, rs2_fwd_valid, rs2_fwd, b, fv, fwd);
      end
      clock_cycle();
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_fill();
    test_full_commit_wrap();
    test_ooo_wb();
    test_forwarding();
    test_flush();
    test_decode_exception();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- In-order issue / in-order commit scoreboard between decode/issue and the commit stage.
- Holds up to NR_SB_ENTRIES in-flight scoreboard_entry records (ariane_pkg), each tagged with a trans_id.
- Collects results and exceptions from NR_WB_PORTS functional-unit writeback ports.
- Presents the oldest entry to commit, and answers issue-side operand hazard/forwarding queries for rs1/rs2.

Parameters:
- NR_ENTRIES, default NR_SB_ENTRIES (4): buffer depth. Must be a power of two.
- NR_WB, default NR_WB_PORTS (3): number of writeback ports.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  discard all in-flight entries.
- issue_entry_i  in  $bits(scoreboard_entry)  decoded instruction.
- issue_valid_i  in  1  issue request.
- issue_ready_o  out  1  space available.
- trans_id_o  out  TRANS_ID_BITS  slot the next issue will occupy.
- rs1_i, rs2_i  in  5 each  operand register addresses to query.
- rs1_busy_o, rs2_busy_o  out  1 each  an in-flight entry writes that register.
- rs1_fwd_valid_o, rs2_fwd_valid_o  out  1 each  the youngest such writer has its result.
- rs1_fwd_o, rs2_fwd_o  out  64 each  that result.
- wb_valid_i  in  NR_WB  writeback strobe per port.
- wb_trans_id_i  in  NR_WB*TRANS_ID_BITS  target slot per port.
- wb_data_i  in  NR_WB*64  result per port.
- wb_ex_i  in  NR_WB*$bits(exception)  exception per port.
- commit_o  out  $bits(scoreboard_entry)  head entry.
- commit_valid_o  out  1  head entry complete.
- commit_ack_i  in  1  commit consumed the head.

Behaviour:
- Storage and state:
  - Circular array mem[NR_ENTRIES] with per-slot allocated bit.
  - issue_ptr and commit_ptr, each TRANS_ID_BITS wide, wrapping naturally.
  - count, 0..NR_ENTRIES.
- Reset (rst_i=1 at a clock edge):
  - Pointers = 0, count = 0, all allocated and valid bits = 0. mem payload need not be reset.
  - Resulting outputs: issue_ready_o=1, trans_id_o=0, commit_valid_o=0, all busy/fwd_valid = 0.
- Flush: identical effect to reset. It has priority over issue, writeback and commit in the same cycle.
- Issue:
  - issue_ready_o = (count != NR_ENTRIES), derived from registered state only. There is no combinational path from commit_ack_i.
  - When full, a commit in the same cycle does not enable issue.
  - On issue_valid_i && issue_ready_o, the next edge writes issue_entry_i into mem[issue_ptr] with:
    - trans_id overwritten with issue_ptr;
    - valid forced to issue_entry_i.ex.valid, so exceptions from decode commit without writeback.
  - Then issue_ptr+1, slot allocated.
  - trans_id_o = issue_ptr, combinational.
- Writeback, per port p with wb_valid_i[p]:
  - If the slot is allocated: result <= wb_data_i[p], valid <= 1.
  - If wb_ex_i[p].valid: ex <= wb_ex_i[p].
  - Writeback to an unallocated slot is ignored, including the slot being issued this same cycle.
  - Two ports targeting the same slot in one cycle: the highest port index wins. This is a protocol error and is flagged by an assertion.
- Commit:
  - commit_o = mem[commit_ptr]; commit_valid_o = (count != 0) && mem[commit_ptr].valid.
  - commit_ack_i while commit_valid_o: the slot is deallocated, its valid is cleared, and commit_ptr+1.
  - commit_ack_i while !commit_valid_o is ignored.
  - Writeback to the head slot becomes visible on commit_valid_o in the next cycle.
- Count update:
  - Issue and commit in the same cycle leave count unchanged.
  - count never exceeds NR_ENTRIES and never goes below 0.
- Operand query (combinational, registered state only; same-cycle writeback is not bypassed):
  - For rsX != 0, search allocated entries from youngest (issue_ptr-1) back to commit_ptr for rd == rsX.
  - busy = a match exists.
  - fwd_valid = the youngest match has valid=1 and ex.valid=0; fwd = its result.
  - rsX == 0 gives busy=0 and fwd_valid=0.
  - fwd is don't-care when fwd_valid=0.

Test Plan:
- Reset, then issue 4 entries with no commit → trans_id_o sequence 0,1,2,3; issue_ready_o=0 after the 4th; a 5th issue_valid_i is not accepted.
- Full, with wb on trans_id 0 data 0xDEAD and commit_ack_i together with issue_valid_i → commit_o.result=0xDEAD; no issue in the ack cycle; issue accepted next cycle as trans_id 0 (wrap-around).
- Out-of-order wb on ids 2,1,0 over 3 cycles, ack held high → commits come out in order 0,1,2; commit_valid_o stays low until id 0 is written back.
- Issue rd=5 twice (ids 0,1), wb only id 0 with 0x11, query rs1=5 → busy=1, fwd_valid=0. After wb id 1 with 0x22 → fwd_valid=1, fwd=0x22. Query rs1=0 → busy=0.
- Issue 3 entries, flush_i asserted together with issue_valid_i and wb on id 1 → next cycle count 0, commit_valid_o=0, trans_id_o=0, issue_ready_o=1.
- Issue an entry with ex.valid=1 and cause ILLEGAL_INSTR (2) → commit_valid_o=1 the next cycle without any wb; commit_o.ex.cause=2.
